booth_r4_seq_mul: RTL and testbench

Iterative radix-4 Booth multiplier sequencer for 32×32-bit operands, signed or unsigned, selected per operation. Accepts one operand pair through a valid/ready handshake and recodes the multiplier into one Booth digit per cycle. Drives a single shared partial-product generator with that digit and accumulates the 64-bit product. It is the low-area, multi-cycle alternative to the fully parallel partial-product array, and it returns the product through a second valid/ready handshake.

---
 rtl/booth_r4_seq_mul_pkg.sv | 29 ++
 rtl/booth_r4_digit_pp.sv | 24 ++
 rtl/booth_r4_seq_mul.sv | 90 +++++++++
 tb/tb_booth_r4_seq_mul.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/booth_r4_seq_mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package booth_r4_seq_mul_pkg;

    localparam int ITERS = 17;
    localparam int OPW   = 32;
    localparam int PRODW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_dig_t;

    // {b[2i+1], b[2i], b[2i-1]} -> one-hot magnitude plus sign; 000/111 give all-zero
    function automatic booth_dig_t booth_recode(input logic [2:0] bits);
        booth_dig_t d;
        d.neg = bits[2] & ~(bits[1] & bits[0]);
        d.one = bits[1] ^ bits[0];
        d.two = (bits == 3'b011) || (bits == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_digit_pp.sv
// Combinational radix-4 Booth partial product: recodes 3 multiplier bits and scales M.
module booth_r4_digit_pp
    import booth_r4_seq_mul_pkg::*;
(
    input  logic [2:0]         i_bits,
    input  logic [32:0]        i_m,
    output logic signed [34:0] o_pp
);

    booth_dig_t  w_dig;
    logic [34:0] w_mag;

    always_comb begin
        w_dig = booth_recode(i_bits);
        w_mag = '0;
        if (w_dig.one)
            w_mag = {{2{i_m[32]}}, i_m};
        else if (w_dig.two)
            w_mag = {i_m[32], i_m, 1'b0};
        // -2*(-2^32) = 2^33 still fits in 35 signed bits
        o_pp = w_dig.neg ? -w_mag : w_mag;
    end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth 32x32 multiplier, one digit per cycle, signed/unsigned per op.
// Optional BOOTH_SEQ_EARLY_TERM_EN: stop once all remaining Booth digits are zero.
module booth_r4_seq_mul
    import booth_r4_seq_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] mulcand,
    input  logic [31:0] mulplier,
    input  logic        sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [34:0]        r_b;        // {b[33:0], b[-1]}, arithmetic-shifted right 2 per digit
    logic [32:0]        r_m;
    logic [PRODW-1:0]   r_acc;
    logic [4:0]         r_cnt;
    logic signed [34:0] w_pp;
    logic [PRODW-1:0]   w_pp_sh;
    logic               w_last;

    booth_r4_digit_pp u_pp (
        .i_bits (r_b[2:0]),
        .i_m    (r_m),
        .o_pp   (w_pp)
    );

    assign w_pp_sh = {{29{w_pp[34]}}, w_pp} << {r_cnt, 1'b0};

`ifdef BOOTH_SEQ_EARLY_TERM_EN
    // r_b[34:2] holds b[33:2i+1] padded with b[33]; uniform means every later digit is 0
    assign w_last = (r_cnt == 5'(ITERS - 1)) || (&r_b[34:2]) || ~(|r_b[34:2]);
`else
    assign w_last = (r_cnt == 5'(ITERS - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = ITER;
            ITER:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state == ITER);
        out_valid = (r_state == DONE);
        result    = r_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b   <= '0;
            r_m   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_b   <= {{2{sign & mulplier[31]}}, mulplier, 1'b0};
                    r_m   <= {sign & mulcand[31], mulcand};
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                ITER: begin
                    r_acc <= r_acc + w_pp_sh;
                    r_cnt <= r_cnt + 5'd1;
                    r_b   <= {{2{r_b[34]}}, r_b[34:2]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed bench for booth_r4_seq_mul with an arithmetic reference model and per-cycle checker.
module tb_booth_r4_seq_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mulcand;
    logic [31:0] mulplier;
    logic        sign;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    booth_r4_seq_mul dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mulcand   (mulcand),
        .mulplier  (mulplier),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] prod_model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int lat_model(input logic [31:0] mp, input logic s);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
        logic [33:0] b;
        bit ok;
        b = {{2{s & mp[31]}}, mp};
        for (int k = 1; k <= 17; k++) begin
            ok = 1'b1;
            for (int j = 2*k-1; j <= 33; j++)
                if (b[j] != b[33]) ok = 1'b0;
            if (ok) return k;
        end
        return 17;
`else
        return 17;
`endif
    endfunction

    // per-cycle checker: any presented product must match the oldest expected one
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0)
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                else begin
                    chk("result", result, exp_q[0]);
                    chk("in_ready_in_done", 64'(in_ready), 64'd0);
                    chk("busy_in_done", 64'(busy), 64'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (busy) begin
                chk("in_ready_in_iter", 64'(in_ready), 64'd0);
                chk("out_valid_in_iter", 64'(out_valid), 64'd0);
            end
        end
    end

    task automatic do_op(input logic [31:0] mc, input logic [31:0] mp, input logic sg,
                         input logic [63:0] lit, input int lit_lat, input int hold, input bit pulse);
        int to;
        int lat;
        int elat;
        to = 0;
        while (!in_ready && to < 50) begin @(posedge clk); #1; to++; end
        chk("wait_in_ready", 64'(in_ready), 64'd1);
        mulcand = mc; mulplier = mp; sign = sg; in_valid = 1'b1;
        chk("model_vs_literal", prod_model(mc, mp, sg), lit);
        elat = lat_model(mp, sg);
        if (lit_lat > 0) chk("latmodel_vs_literal", 64'(elat), 64'(lit_lat));
        exp_q.push_back(prod_model(mc, mp, sg));
        @(posedge clk); #1;
        in_valid = 1'b0; mulcand = $urandom; mulplier = $urandom; sign = ~sg;
        chk("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("latency", 64'(lat), 64'(elat));
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                in_valid = 1'b1; mulcand = $urandom; mulplier = $urandom;
            end
            @(posedge clk); #1;
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_result", result, lit);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_release", 64'(in_ready), 64'd1);
        chk("out_valid_after_release", 64'(out_valid), 64'd0);
        out_ready = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mulcand = '0; mulplier = '0; sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;

        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 0, 0, 0);
        do_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 0, 0, 0);
        do_op(32'hFFFFFFFF, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFF9, 0, 0, 0);
        do_op(32'hFFFFFFFF, 32'h00000007, 1'b0, 64'h00000006FFFFFFF9, 0, 0, 0);
        do_op(32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA, 0, 0, 0);
        do_op(32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, 0, 0, 0);
        do_op(32'h00001234, 32'h00000010, 1'b0, 64'h0000000000012340, 0, 5, 1);

        // abort mid-operation
        mulcand = 32'h0000ABCD; mulplier = 32'h7FFFFFFF; sign = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("busy_iter8", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", result, 64'd0);
        do_op(32'd5, 32'd6, 1'b0, 64'd30, 0, 0, 0);

`ifdef BOOTH_SEQ_EARLY_TERM_EN
        do_op(32'd5, 32'd3, 1'b0, 64'd15, 2, 0, 0);
        do_op(32'd9, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFF7, 1, 0, 0);
        do_op(32'h00001234, 32'd0, 1'b1, 64'd0, 1, 0, 0);
`else
        do_op(32'd5, 32'd3, 1'b0, 64'd15, 17, 0, 0);
        do_op(32'd9, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFF7, 17, 0, 0);
        do_op(32'h00001234, 32'd0, 1'b1, 64'd0, 17, 0, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_idle", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
